// File: rtl/strm_pkg.sv
// Shared sizing helpers and slack rules for the weight-streamer output buffers.
package strm_pkg;

  // Words the streamer can still deliver after it sees afull rise.
  localparam int MIN_SLACK = 6;

  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit slack_ok(input int depth, input int thresh);
    return (depth - thresh) >= MIN_SLACK;
  endfunction

endpackage

// File: rtl/strm_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read (maps to LUTRAM).
module strm_fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 31,
  parameter int AW    = 5
) (
  input  logic             aclk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; occupancy tracking alone decides which entries are meaningful.
  always_ff @(posedge aclk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/strm_afull_fifo.sv
// FWFT output buffer: valid-only push side, AXI-Stream master side, registered almost-full.
module strm_afull_fifo
  import strm_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 32,
  parameter int AFULL_THRESH = DEPTH - 8,
  localparam int CW          = count_w(DEPTH)
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic             s_tvalid,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             afull,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int              PW         = $clog2(DEPTH);
  localparam int              RAM_DEPTH  = DEPTH - 1;
  localparam logic [PW-1:0]   PTR_LAST   = PW'(RAM_DEPTH - 1);
  localparam logic [CW-1:0]   FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0]   THRESH_CNT = CW'(AFULL_THRESH);

  if (!slack_ok(DEPTH, AFULL_THRESH)) begin : g_bad_slack
    $fatal(1, "strm_afull_fifo: DEPTH-AFULL_THRESH below streamer in-flight slack");
  end
  if ((DEPTH < 8) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "strm_afull_fifo: DEPTH must be a power of 2 and at least 8");
  end

  logic [CW-1:0]    r_count;
  logic             r_head_valid;
  logic [WIDTH-1:0] r_head_data;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             r_afull;
  logic             r_overflow;

  logic             w_pop;
  logic             w_accept;
  logic             w_push;
  logic             w_head_load;
  logic             w_ram_empty;
  logic             w_from_ram;
  logic             w_bypass;
  logic             w_ram_wr;
  logic [CW-1:0]    w_ram_count;
  logic [CW-1:0]    w_count_next;
  logic [WIDTH-1:0] w_ram_rd_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign w_pop        = r_head_valid & m_tready;
  // When full, a push is only room-safe if the head drains on the same edge.
  assign w_accept     = (r_count != FULL_CNT) | w_pop;
  assign w_push       = s_tvalid & w_accept;
  assign w_head_load  = ~r_head_valid | w_pop;
  assign w_ram_count  = r_count - CW'(r_head_valid);
  assign w_ram_empty  = (w_ram_count == '0);
  assign w_from_ram   = w_head_load & ~w_ram_empty;
  assign w_bypass     = w_head_load & w_ram_empty & w_push;
  assign w_ram_wr     = w_push & ~w_bypass;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  strm_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (RAM_DEPTH),
    .AW    (PW)
  ) u_ram (
    .aclk      (aclk),
    .i_wr_en   (w_ram_wr),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (s_tdata),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_rd_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (rst) begin
      r_count      <= '0;
      r_head_valid <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_afull      <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_count    <= w_count_next;
      r_afull    <= (w_count_next >= THRESH_CNT);
      r_overflow <= r_overflow | (s_tvalid & ~w_accept);
      if (w_head_load) r_head_valid <= ~w_ram_empty | w_push;
      if (w_from_ram)  r_rd_ptr     <= ptr_inc(r_rd_ptr);
      if (w_ram_wr)    r_wr_ptr     <= ptr_inc(r_wr_ptr);
    end
  end

  // Head data needs no reset; r_head_valid qualifies it.
  always_ff @(posedge aclk) begin
    if (w_from_ram)    r_head_data <= w_ram_rd_data;
    else if (w_bypass) r_head_data <= s_tdata;
  end

  assign m_tvalid = r_head_valid;
  assign m_tdata  = r_head_data;
  assign count    = r_count;
  assign afull    = r_afull;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_strm_afull_fifo.sv
// Randomized scoreboard bench for strm_afull_fifo against a queue-based reference model.
module tb_strm_afull_fifo;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int THRESH = DEPTH - 8;
  localparam int CW     = $clog2(DEPTH + 1);

  logic             aclk = 1'b0;
  logic             rst;
  logic             s_tvalid;
  logic [WIDTH-1:0] s_tdata;
  logic             afull;
  logic             m_tvalid;
  logic             m_tready;
  logic [WIDTH-1:0] m_tdata;
  logic [CW-1:0]    count;
  logic             overflow;

  strm_afull_fifo #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (THRESH)
  ) dut (
    .aclk     (aclk),
    .rst      (rst),
    .s_tvalid (s_tvalid),
    .s_tdata  (s_tdata),
    .afull    (afull),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .count    (count),
    .overflow (overflow)
  );

  always #5 aclk = ~aclk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the FIFO is a queue of accepted words; occupancy is its size.
  logic [WIDTH-1:0] exp_q[$];
  int               m_cnt      = 0;
  bit               m_ovf      = 1'b0;
  bit               model_live = 1'b0;
  bit               rand_phase = 1'b0;
  int               rand_out   = 0;

  // Inputs change 1ns after each rising edge, so at the falling edge both the
  // post-edge outputs and the inputs for the coming edge are visible.
  always @(negedge aclk) begin
    bit pop, acc;
    if (rst) begin
      model_live = 1'b1;
      m_cnt      = 0;
      m_ovf      = 1'b0;
      exp_q.delete();
    end else if (model_live) begin
      check("count",    64'(count),    64'(m_cnt));
      check("m_tvalid", 64'(m_tvalid), 64'(m_cnt > 0));
      check("afull",    64'(afull),    64'(m_cnt >= THRESH));
      check("overflow", 64'(overflow), 64'(m_ovf));
      pop = (m_cnt > 0) && m_tready;
      acc = (m_cnt < DEPTH) || pop;
      if (s_tvalid) begin
        if (acc) exp_q.push_back(s_tdata);
        else     m_ovf = 1'b1;
      end
      m_cnt = m_cnt + ((s_tvalid && acc) ? 1 : 0) - (pop ? 1 : 0);
    end
  end

  // Output monitor: pops the scoreboard on every handshake and checks stall stability.
  bit               prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data;
  always @(negedge aclk) begin
    if (rst || !model_live) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && m_tvalid) check("m_tdata_stable", 64'(m_tdata), 64'(prev_data));
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) check("unexpected_word", 64'(m_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
        else                   check("m_tdata", 64'(m_tdata), 64'(exp_q.pop_front()));
        if (rand_phase) rand_out++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end
  end

  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic rdy);
    @(posedge aclk);
    #1;
    rst      = 1'b0;
    s_tvalid = v;
    s_tdata  = d;
    m_tready = rdy;
  endtask

  task automatic reset_cycle(input logic v, input logic [WIDTH-1:0] d);
    @(posedge aclk);
    #1;
    rst      = 1'b1;
    s_tvalid = v;
    s_tdata  = d;
    m_tready = 1'b1;
  endtask

  task automatic drain(input int n);
    repeat (n) step(1'b0, '0, 1'b1);
  endtask

  initial begin
    logic [5:0] afull_dly;
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    repeat (3) @(posedge aclk);

    // Single word through the bypass path.
    step(1'b1, 32'hA5A5_A5A5, 1'b1);
    drain(4);

    // Fill to the threshold while stalled, then release.
    for (int i = 0; i < 24; i++) step(1'b1, WIDTH'(i), 1'b0);
    step(1'b0, '0, 1'b0);
    drain(30);

    // Streaming: one push and one pop every cycle.
    for (int i = 0; i < 1000; i++) step(1'b1, WIDTH'(32'h1000_0000 + i), 1'b1);
    drain(4);

    // Fill completely, drop one word, then push with a simultaneous pop.
    for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(32'h2000_0000 + i), 1'b0);
    step(1'b1, 32'h0000_DEAD, 1'b0);
    step(1'b1, 32'h0000_BEEF, 1'b1);
    step(1'b0, '0, 1'b0);
    drain(40);

    // Random backpressure with the streamer reacting to afull through a delay line.
    reset_cycle(1'b0, '0);
    afull_dly  = '0;
    rand_phase = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      step(!afull_dly[5] && ($urandom_range(0, 3) != 0), WIDTH'($urandom), $urandom_range(0, 1) == 1);
      afull_dly = {afull_dly[4:0], afull};
    end
    drain(40);
    rand_phase = 1'b0;
    check("random_wraps", 64'(rand_out >= 3 * (DEPTH - 1)), 64'd1);

    // Reset while holding 17 words; the push during reset must be ignored.
    for (int i = 0; i < 17; i++) step(1'b1, WIDTH'(32'h3000_0000 + i), 1'b0);
    reset_cycle(1'b1, 32'h0BAD_0BAD);
    step(1'b1, 32'h0000_1234, 1'b1);
    drain(5);

    check("final_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/strm_afull_fifo.md
# strm_afull_fifo

Per-stream output buffer placed directly downstream of each weight-streamer output port. Accepts a valid-only push stream (no backpressure), stores it in a first-word-fall-through FIFO, and presents a standard AXI-Stream master to the consumer (MVAU / thresholding). It generates the registered almost-full flag that throttles the streamer. The threshold is sized so that words already in the streamer's read pipeline always fit after the flag rises.

## Interface
Parameters:
- WIDTH, 32: tdata width in bits; a multiple of 8, matching the streamer's padded port width.
- DEPTH, 32: storage words including the output register; a power of 2, at least 8.
- AFULL_THRESH, DEPTH-8: occupancy at or above which afull is high. Elaboration fails unless DEPTH-AFULL_THRESH ≥ 6, which covers the streamer's in-flight words.

Ports:
- aclk, in, 1: clock; all logic is rising-edge.
- rst, in, 1: synchronous, active-high reset; clock aclk.
- s_tvalid, in, 1: push strobe. There is no ready signal; a word is written every cycle this is high.
- s_tdata, in, WIDTH: push data.
- afull, out, 1: almost-full, to the streamer's afull input.
- m_tvalid, out, 1: output word valid.
- m_tready, in, 1: consumer ready.
- m_tdata, out, WIDTH: output word.
- count, out, $clog2(DEPTH+1): current occupancy.
- overflow, out, 1: sticky; set when a push is dropped.

## Operation
- Storage has two parts: a (DEPTH-1)-entry circular RAM with wr_ptr and rd_ptr of $clog2(DEPTH) bits (pointer wrap at DEPTH-1 handled explicitly), plus a head register that drives m_tdata and m_tvalid.
- pop = m_tvalid & m_tready. push = s_tvalid & accepted.
- A push is accepted when count < DEPTH, or when count == DEPTH and pop is high in the same cycle.
- A rejected push drops its word, sets overflow, and leaves count unchanged.
- Head load rule, applied when the head is empty or is popping this cycle:
  - If the RAM is non-empty, the head loads RAM[rd_ptr] and rd_ptr increments.
  - Else, if push is high, the head loads s_tdata directly (bypass); the RAM is not written.
  - Else, the head becomes empty.
- Otherwise a push writes RAM[wr_ptr] and wr_ptr increments.
- Ordering is strictly FIFO, including bypass-versus-RAM arbitration. Bypass is only allowed when the RAM is empty.
- count_next = count + push − pop. Push and pop in the same cycle leave count unchanged.
- afull is a register: afull <= (count_next ≥ AFULL_THRESH). As a result afull == (count ≥ AFULL_THRESH) in every cycle.
- m_tdata holds stable while m_tvalid & ~m_tready.
- overflow clears only on rst.

## Timing
- Reset values: count=0, m_tvalid=0, afull=0, overflow=0, pointers=0. m_tdata is don't-care.
- rst mid-operation discards all contents. Pushes in the reset cycle are ignored.
- Latency when empty: a push at edge t gives m_tvalid=1 with that data after edge t, i.e. 1 cycle.
- Throughput: 1 word/cycle sustained with m_tready held high. No bubbles at the RAM/bypass switchover.
- afull rises in the same cycle count reaches AFULL_THRESH. It falls in the same cycle count drops below AFULL_THRESH.
- Full (count==DEPTH): a push with a simultaneous pop is accepted, and count stays at DEPTH. A push without a pop is dropped.
- Empty (count==0): m_tvalid=0 and m_tready is ignored.

## Structure
- Package strm_pkg holds the width helper for count (clog2 of DEPTH+1) and the elaboration assertion on slack, both shared with the streamer wrapper.
- One sub-module, strm_fifo_ram: a simple dual-port RAM with one synchronous write port and one asynchronous read port, so it maps to LUTRAM. Its depth is DEPTH-1 and its width is WIDTH.
- Head register, pointers, count, afull and overflow live in strm_afull_fifo.

## Test plan
- Reset then a single push of 0xA5A5A5A5 with m_tready=1: m_tvalid high after one edge with m_tdata=0xA5A5A5A5, then low; count follows 0→1→0.
- m_tready=0, 24 consecutive pushes of values 0..23 (DEPTH=32, THRESH=24): afull goes high in the cycle count=24. Then release m_tready: outputs 0..23 in order, and afull falls when count=23.
- Continuous push and continuous pop of a 1000-word incrementing stream: m_tvalid is never low after the first word, output equals input, count stays at 1.
- Fill to count=32, then push 0xDEAD with m_tready=0: word dropped, overflow=1, count=32. Then push and pop together: accepted, count=32. overflow stays 1 until rst.
- Random m_tready at 50% with pushes gated by afull through a 6-cycle delay line: no overflow, output order preserved across pointer wrap (≥3 full wraps).
- Assert rst with count=17: next cycle count=0, m_tvalid=0, afull=0, and the first post-reset push appears with 1-cycle latency.
